operand_fetch_stage: RTL and testbench

// - Reads vector source operands from the VRF and streams them, one 128-bit slice per beat, to the arith stage.
// - Sits between instruction decode and the arith stage and supplies vs1/vs2/vs3 slices, cycle_count and a byte mask.
// - Handles multi-cycle vectors (VL/SEW-dependent slice count) and 1-cycle synchronous VRF read latency.
// - Tolerates downstream stalls without dropping or duplicating slices.

---
 rtl/operand_fetch_if.sv | 47 ++++
 rtl/operand_fetch_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if
// Groups the decode, VRF-read and arith-stage handshake signals of the
// operand fetch stage into one bundle.
//   Decode side : instr_valid/instr_ready, vs1/vs2/vs3_addr, vl, vsew
//   VRF side    : vrf_rd_en, vrf_rd_addr1..3 (out), vrf_rd_data1..3 (in)
//   Arith side  : op_valid/op_ready, vs1..3_data, cycle_count, byte_en, op_last
// Modports:
//   master - the operand fetch stage itself
//   slave  - the surrounding environment (decode, VRF, arith stage)
interface operand_fetch_if;
    logic           instr_valid;
    logic           instr_ready;
    logic [4:0]     vs1_addr;
    logic [4:0]     vs2_addr;
    logic [4:0]     vs3_addr;
    logic [4:0]     vl;
    logic [1:0]     vsew;
    logic           vrf_rd_en;
    logic [6:0]     vrf_rd_addr1;
    logic [6:0]     vrf_rd_addr2;
    logic [6:0]     vrf_rd_addr3;
    logic [127:0]   vrf_rd_data1;
    logic [127:0]   vrf_rd_data2;
    logic [127:0]   vrf_rd_data3;
    logic           op_valid;
    logic           op_ready;
    logic [127:0]   vs1_data;
    logic [127:0]   vs2_data;
    logic [127:0]   vs3_data;
    logic [1:0]     cycle_count;
    logic [15:0]    byte_en;
    logic           op_last;

    modport master (
        input  instr_valid, vs1_addr, vs2_addr, vs3_addr, vl, vsew,
        input  vrf_rd_data1, vrf_rd_data2, vrf_rd_data3, op_ready,
        output instr_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, vrf_rd_addr3,
        output op_valid, vs1_data, vs2_data, vs3_data, cycle_count, byte_en, op_last
    );

    modport slave (
        output instr_valid, vs1_addr, vs2_addr, vs3_addr, vl, vsew,
        output vrf_rd_data1, vrf_rd_data2, vrf_rd_data3, op_ready,
        input  instr_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, vrf_rd_addr3,
        input  op_valid, vs1_data, vs2_data, vs3_data, cycle_count, byte_en, op_last
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Reads vs1/vs2/vs3 operands from the VRF one 128-bit slice at a time and
// streams them to the arith stage with slice index, byte mask and last flag.
// VLEN = 512 (4 slices), 1-cycle synchronous VRF read latency, 2-entry
// output skid buffer.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - operand_fetch_if.master (decode, VRF and arith handshakes)
// Configuration:
//   OPERAND_FETCH_VS3_EN defined   : vs3 is fetched and buffered.
//   OPERAND_FETCH_VS3_EN undefined : vrf_rd_addr3 and vs3_data are 0,
//                                    vrf_rd_data3 is ignored.
module operand_fetch_stage (
    input  logic                   clk,
    input  logic                   reset,
    operand_fetch_if.master        bus
);
    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [127:0] vs1;
        logic [127:0] vs2;
`ifdef OPERAND_FETCH_VS3_EN
        logic [127:0] vs3;
`endif
        logic [1:0]   slice;
        logic [15:0]  be;
        logic         last;
    } skid_entry_t;

    // Byte mask of slice k for a vector holding 'bytes' active bytes.
    function automatic logic [15:0] slice_byte_en(input logic [6:0] bytes,
                                                  input logic [1:0] k);
        logic [6:0]  base;
        logic [6:0]  rem;
        logic [15:0] m;
        base = {1'b0, k, 4'b0000};
        rem  = 7'd0;
        if (bytes >= (base + 7'd16)) begin
            m = 16'hFFFF;
        end else if (bytes <= base) begin
            m = 16'h0000;
        end else begin
            rem = bytes - base;
            m   = (16'h0001 << rem[3:0]) - 16'h0001;
        end
        return m;
    endfunction

    state_e         state_q, state_d;
    logic [4:0]     vs1_q, vs2_q, vs3_q;
    logic [6:0]     bytes_q;
    logic [1:0]     last_slice_q;
    logic [1:0]     slice_q;
    logic           inflight_q;
    logic [1:0]     rd_slice_q;
    logic           rd_last_q;
    skid_entry_t    skid_q [SKID_DEPTH];
    logic           wr_ptr_q, rd_ptr_q;
    logic [1:0]     count_q;

    logic [1:0]     vsew_eff_s;
    logic [6:0]     bytes_s;
    logic [6:0]     bytes_clamp_s;
    logic [1:0]     last_slice_s;
    logic           pop_s;
    logic           credit_ok_s;
    logic           rd_last_s;
    logic [1:0]     count_after_pop_s;
    logic           instr_ready_s;
    logic           rd_en_s;
    logic           accept_s;
    skid_entry_t    push_entry_s;
    skid_entry_t    head_s;

    // Decode-time size computation: total bytes clamped to one full register.
    always_comb begin
        vsew_eff_s    = (bus.vsew == 2'd3) ? 2'd2 : bus.vsew;
        bytes_s       = {2'b00, bus.vl} << vsew_eff_s;
        if (bytes_s > 7'd64) begin
            bytes_clamp_s = 7'd64;
        end else begin
            bytes_clamp_s = bytes_s;
        end
        last_slice_s  = 2'((bytes_clamp_s - 7'd1) >> 4);
    end

    // Credit check: a read may issue only if its data is sure to find a free
    // skid entry. A beat leaving this cycle frees an entry, so it is credited
    // to keep one beat per clock with op_ready held high.
    always_comb begin
        pop_s             = (count_q != 2'd0) && bus.op_ready;
        credit_ok_s       = (({1'b0, count_q} + {2'b00, inflight_q}) <
                             (3'(SKID_DEPTH) + {2'b00, pop_s}));
        rd_last_s         = (slice_q == last_slice_q);
        count_after_pop_s = count_q - {1'b0, pop_s};
    end

    // FSM next state and control outputs.
    always_comb begin
        state_d       = state_q;
        instr_ready_s = 1'b0;
        rd_en_s       = 1'b0;
        accept_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready_s = 1'b1;
                if (bus.instr_valid) begin
                    accept_s = 1'b1;
                    // vl == 0 is accepted but produces nothing.
                    if (bus.vl != 5'd0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                rd_en_s = credit_ok_s;
                if (credit_ok_s && rd_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Leave as the last beat is handed off so instr_ready is back
                // the very next cycle.
                if (!inflight_q && (count_after_pop_s == 2'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Assemble the skid entry from the returning VRF data.
    always_comb begin
        push_entry_s       = '0;
        push_entry_s.vs1   = bus.vrf_rd_data1;
        push_entry_s.vs2   = bus.vrf_rd_data2;
`ifdef OPERAND_FETCH_VS3_EN
        push_entry_s.vs3   = bus.vrf_rd_data3;
`endif
        push_entry_s.slice = rd_slice_q;
        push_entry_s.be    = slice_byte_en(bytes_q, rd_slice_q);
        push_entry_s.last  = rd_last_q;
        head_s             = skid_q[rd_ptr_q];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction context, read slice counter and in-flight read tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs1_q        <= 5'd0;
            vs2_q        <= 5'd0;
            vs3_q        <= 5'd0;
            bytes_q      <= 7'd0;
            last_slice_q <= 2'd0;
            slice_q      <= 2'd0;
            inflight_q   <= 1'b0;
            rd_slice_q   <= 2'd0;
            rd_last_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                vs1_q        <= bus.vs1_addr;
                vs2_q        <= bus.vs2_addr;
                vs3_q        <= bus.vs3_addr;
                bytes_q      <= bytes_clamp_s;
                last_slice_q <= last_slice_s;
                slice_q      <= 2'd0;
            end else if (rd_en_s) begin
                slice_q      <= slice_q + 2'd1;
            end
            inflight_q <= rd_en_s;
            rd_slice_q <= slice_q;
            rd_last_q  <= rd_last_s;
        end
    end

    // Skid buffer: push the returning read, pop on a transferred beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                skid_q[wr_ptr_q] <= push_entry_s;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

    assign bus.instr_ready  = instr_ready_s;
    assign bus.vrf_rd_en    = rd_en_s;
    assign bus.vrf_rd_addr1 = {vs1_q, slice_q};
    assign bus.vrf_rd_addr2 = {vs2_q, slice_q};
    assign bus.op_valid     = (count_q != 2'd0);
    assign bus.vs1_data     = head_s.vs1;
    assign bus.vs2_data     = head_s.vs2;
    assign bus.cycle_count  = head_s.slice;
    assign bus.byte_en      = head_s.be;
    assign bus.op_last      = head_s.last;

`ifdef OPERAND_FETCH_VS3_EN
    assign bus.vrf_rd_addr3 = {vs3_q, slice_q};
    assign bus.vs3_data     = head_s.vs3;
`else
    logic unused_vs3_s;
    assign unused_vs3_s     = (^bus.vrf_rd_data3) ^ (^vs3_q);
    assign bus.vrf_rd_addr3 = 7'd0;
    assign bus.vs3_data     = 128'd0;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    operand_fetch_if bus();

    operand_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference VRF content: tag identifies the port, address embedded.
    function automatic logic [127:0] vrf_word(input logic [7:0] tag, input logic [6:0] addr);
        return {4{tag, 1'b0, addr, 16'hC3A5}};
    endfunction

    function automatic logic [127:0] exp_vs3(input logic [4:0] r, input logic [1:0] k);
`ifdef OPERAND_FETCH_VS3_EN
        return vrf_word(8'h33, {r, k});
`else
        return 128'd0;
`endif
    endfunction

    function automatic logic [6:0] exp_addr3(input logic [4:0] r, input logic [1:0] k);
`ifdef OPERAND_FETCH_VS3_EN
        return {r, k};
`else
        return 7'd0;
`endif
    endfunction

    // Synchronous VRF model with 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.vrf_rd_en) begin
            bus.vrf_rd_data1 <= vrf_word(8'h11, bus.vrf_rd_addr1);
            bus.vrf_rd_data2 <= vrf_word(8'h22, bus.vrf_rd_addr2);
            bus.vrf_rd_data3 <= vrf_word(8'h33, bus.vrf_rd_addr3);
        end
    end

    task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic [4:0] vl, input logic [1:0] sew);
        @(negedge clk);
        bus.vs1_addr = a1; bus.vs2_addr = a2; bus.vs3_addr = a3;
        bus.vl = vl; bus.vsew = sew; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready: got %0h expected 1", bus.instr_ready); end
        checks++; if (bus.vrf_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0h expected 0", bus.vrf_rd_en); end
        checks++; if (bus.op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %0h expected 0", bus.op_valid); end
        checks++; if (bus.op_last !== 1'b0) begin errors++; $display("FAIL reset_op_last: got %0h expected 0", bus.op_last); end
        checks++; if ({bus.vs1_data, bus.vs2_data, bus.vs3_data} !== 384'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.vs1_data); end
        checks++; if ({bus.vrf_rd_addr1, bus.vrf_rd_addr2, bus.vrf_rd_addr3, bus.cycle_count, bus.byte_en} !== 39'd0) begin
            errors++; $display("FAIL reset_addr_cc_be: got %h expected 0", {bus.vrf_rd_addr1, bus.cycle_count, bus.byte_en}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        issue(5'd3, 5'd7, 5'd9, 5'd4, 2'd2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin
                checks++; if (bus.vrf_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %0h expected 1", bus.vrf_rd_en); end
                checks++; if (bus.vrf_rd_addr1 !== {5'd3, 2'd0}) begin errors++; $display("FAIL single_addr1: got %h expected %h", bus.vrf_rd_addr1, {5'd3, 2'd0}); end
                checks++; if (bus.vrf_rd_addr3 !== exp_addr3(5'd9, 2'd0)) begin errors++; $display("FAIL single_addr3: got %h expected %h", bus.vrf_rd_addr3, exp_addr3(5'd9, 2'd0)); end
            end
            if (c == 2) begin
                checks++; if ({bus.op_valid, bus.vrf_rd_en} !== 2'b00) begin errors++; $display("FAIL single_c2_valid_rd: got %b expected 00", {bus.op_valid, bus.vrf_rd_en}); end
            end
            if (c == 3) begin
                checks++; if ({bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last} !== {1'b1, 2'd0, 16'hFFFF, 1'b1}) begin
                    errors++; $display("FAIL single_beat: got v=%0h cc=%0d be=%h last=%0h expected v=1 cc=0 be=ffff last=1", bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last); end
                checks++; if (bus.vs1_data !== vrf_word(8'h11, {5'd3, 2'd0})) begin errors++; $display("FAIL single_vs1: got %h expected %h", bus.vs1_data, vrf_word(8'h11, {5'd3, 2'd0})); end
                checks++; if (bus.vs2_data !== vrf_word(8'h22, {5'd7, 2'd0})) begin errors++; $display("FAIL single_vs2: got %h expected %h", bus.vs2_data, vrf_word(8'h22, {5'd7, 2'd0})); end
                checks++; if (bus.vs3_data !== exp_vs3(5'd9, 2'd0)) begin errors++; $display("FAIL single_vs3: got %h expected %h", bus.vs3_data, exp_vs3(5'd9, 2'd0)); end
            end
            if (c == 4) begin
                checks++; if ({bus.op_valid, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL single_done: got valid/ready %b expected 01", {bus.op_valid, bus.instr_ready}); end
            end
        end
    endtask

    task automatic test_two_beats();
        issue(5'd12, 5'd13, 5'd14, 5'd10, 2'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            if (c == 1 || c == 2) begin
                checks++; if ({bus.vrf_rd_en, bus.vrf_rd_addr1} !== {1'b1, 5'd12, 2'(c - 1)}) begin
                    errors++; $display("FAIL two_read%0d: got en=%0h addr=%h expected en=1 addr=%h", c, bus.vrf_rd_en, bus.vrf_rd_addr1, {5'd12, 2'(c - 1)}); end
            end
            if (c == 3 || c == 4) begin
                checks++; if ({bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last} !== {1'b1, 2'(c - 3), (c == 3) ? 16'hFFFF : 16'h000F, (c == 4)}) begin
                    errors++; $display("FAIL two_beat%0d: got v=%0h cc=%0d be=%h last=%0h", c - 3, bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last); end
                checks++; if (bus.vs2_data !== vrf_word(8'h22, {5'd13, 2'(c - 3)})) begin
                    errors++; $display("FAIL two_vs2_%0d: got %h expected %h", c - 3, bus.vs2_data, vrf_word(8'h22, {5'd13, 2'(c - 3)})); end
            end
            if (c == 5) begin
                checks++; if ({bus.op_valid, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL two_done: got %b expected 01", {bus.op_valid, bus.instr_ready}); end
            end
        end
    endtask

    task automatic test_clamp();
        issue(5'd31, 5'd1, 5'd2, 5'd31, 2'd2);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            if (c >= 3 && c <= 6) begin
                checks++; if ({bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last} !== {1'b1, 2'(c - 3), 16'hFFFF, (c == 6)}) begin
                    errors++; $display("FAIL clamp_beat%0d: got v=%0h cc=%0d be=%h last=%0h", c - 3, bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last); end
                checks++; if (bus.vs1_data !== vrf_word(8'h11, {5'd31, 2'(c - 3)})) begin
                    errors++; $display("FAIL clamp_vs1_%0d: got %h expected %h", c - 3, bus.vs1_data, vrf_word(8'h11, {5'd31, 2'(c - 3)})); end
            end
            if (c == 7) begin
                checks++; if ({bus.op_valid, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL clamp_done: got %b expected 01", {bus.op_valid, bus.instr_ready}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(5'd4, 5'd5, 5'd6, 5'd1, 2'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); #1;
            if (c == 3) begin
                checks++; if ({bus.op_valid, bus.byte_en, bus.op_last} !== {1'b1, 16'h0001, 1'b1}) begin
                    errors++; $display("FAIL b2b_first: got v=%0h be=%h last=%0h expected v=1 be=0001 last=1", bus.op_valid, bus.byte_en, bus.op_last); end
            end
            if (c == 4) begin
                checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0h expected 1", bus.instr_ready); end
                bus.vs1_addr = 5'd20; bus.vs2_addr = 5'd21; bus.vs3_addr = 5'd22;
                bus.vl = 5'd8; bus.vsew = 2'd1; bus.instr_valid = 1'b1;
            end
            if (c == 5) bus.instr_valid = 1'b0;
            if (c == 7) begin
                checks++; if ({bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last} !== {1'b1, 2'd0, 16'hFFFF, 1'b1}) begin
                    errors++; $display("FAIL b2b_second: got v=%0h cc=%0d be=%h last=%0h", bus.op_valid, bus.cycle_count, bus.byte_en, bus.op_last); end
                checks++; if (bus.vs1_data !== vrf_word(8'h11, {5'd20, 2'd0})) begin errors++; $display("FAIL b2b_vs1: got %h expected %h", bus.vs1_data, vrf_word(8'h11, {5'd20, 2'd0})); end
            end
        end
    endtask

    task automatic test_stall();
        int got;
        int reads;
        got = 0; reads = 0;
        issue(5'd8, 5'd9, 5'd10, 5'd16, 2'd2);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.op_ready = !(c >= 2 && c <= 5);
            #1;
            if (bus.vrf_rd_en) reads++;
            if (c >= 3 && c <= 5) begin
                checks++; if (bus.vrf_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en_c%0d: got %0h expected 0", c, bus.vrf_rd_en); end
                checks++; if ({bus.op_valid, bus.cycle_count} !== {1'b1, 2'd0} || bus.vs1_data !== vrf_word(8'h11, {5'd8, 2'd0})) begin
                    errors++; $display("FAIL stall_hold_c%0d: got v=%0h cc=%0d vs1=%h", c, bus.op_valid, bus.cycle_count, bus.vs1_data); end
            end
            if (bus.op_valid && bus.op_ready) begin
                checks++; if ({bus.cycle_count, bus.op_last} !== {2'(got), (got == 3)} || bus.vs2_data !== vrf_word(8'h22, {5'd9, 2'(got)})) begin
                    errors++; $display("FAIL stall_beat%0d: got cc=%0d last=%0h vs2=%h", got, bus.cycle_count, bus.op_last, bus.vs2_data); end
                got++;
            end
        end
        bus.op_ready = 1'b1;
        checks++; if (got !== 4) begin errors++; $display("FAIL stall_beat_count: got %0d expected 4", got); end
        checks++; if (reads !== 4) begin errors++; $display("FAIL stall_read_count: got %0d expected 4", reads); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL stall_done: got %0h expected 1", bus.instr_ready); end
    endtask

    task automatic test_vl0();
        issue(5'd1, 5'd2, 5'd3, 5'd0, 2'd2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            checks++; if ({bus.op_valid, bus.vrf_rd_en, bus.instr_ready} !== 3'b001) begin
                errors++; $display("FAIL vl0_c%0d: got valid/rd/ready %b expected 001", c, {bus.op_valid, bus.vrf_rd_en, bus.instr_ready}); end
        end
    endtask

    task automatic test_reset_mid();
        issue(5'd5, 5'd6, 5'd7, 5'd16, 2'd2);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.op_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %0h expected 1", bus.op_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({bus.instr_ready, bus.vrf_rd_en, bus.op_valid, bus.op_last} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_ctrl: got %b expected 1000", {bus.instr_ready, bus.vrf_rd_en, bus.op_valid, bus.op_last}); end
        checks++; if ({bus.vs1_data, bus.vrf_rd_addr1, bus.cycle_count, bus.byte_en} !== 153'd0) begin
            errors++; $display("FAIL rstmid_data: got vs1=%h addr=%h cc=%0d be=%h expected 0", bus.vs1_data, bus.vrf_rd_addr1, bus.cycle_count, bus.byte_en); end
        @(negedge clk);
        reset = 1'b0;
        issue(5'd6, 5'd7, 5'd8, 5'd4, 2'd2);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin
                checks++; if ({bus.vrf_rd_en, bus.vrf_rd_addr1} !== {1'b1, 5'd6, 2'd0}) begin errors++; $display("FAIL rstmid_restart_addr: got %h", bus.vrf_rd_addr1); end
            end
            if (c == 3) begin
                checks++; if ({bus.op_valid, bus.cycle_count, bus.op_last} !== {1'b1, 2'd0, 1'b1} || bus.vs1_data !== vrf_word(8'h11, {5'd6, 2'd0})) begin
                    errors++; $display("FAIL rstmid_restart_beat: got v=%0h cc=%0d vs1=%h", bus.op_valid, bus.cycle_count, bus.vs1_data); end
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.instr_valid = 1'b0; bus.op_ready = 1'b1;
        bus.vs1_addr = 5'd0; bus.vs2_addr = 5'd0; bus.vs3_addr = 5'd0;
        bus.vl = 5'd0; bus.vsew = 2'd0;
        test_reset();
        test_single();
        test_two_beats();
        test_clamp();
        test_back_to_back();
        test_stall();
        test_vl0();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
